// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: merges the instruction-fetch read port and the load/store
// data port onto the single request channel of the CPU-side SDRAM interface.
// It sequences the mem_ready handshake and returns data with a one-cycle ack.
// A busy timeout turns a hung memory into an error completion (bus_err).
//
// Ports:
//   cpu_clk, reset_n                 clock, async active-low reset
//   if_req/if_addr -> if_ack/if_rdata         fetch port (read only)
//   d_ren/d_wen/d_addr/d_wdata/d_be -> d_ack/d_rdata   data port
//   bus_err                           qualifies an ack as a timeout completion
//   mem_ren/mem_wen/mem_addr/mem_wdata/mem_be  request channel to SDRAM i/f
//   mem_rdata/mem_ready               read data and idle/done from SDRAM i/f
//
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// otherwise the data port always wins over the fetch port.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1023
) (
  input  logic              cpu_clk,
  input  logic              reset_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_ren,
  input  logic              d_wen,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              bus_err,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_LOW  = 3'd2,
    WAIT_HIGH = 3'd3,
    RESP      = 3'd4
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              gnt_data_q, gnt_data_d;  // 1: data port owns the transaction
  logic              wr_q, wr_d;              // 1: transaction is a write
  logic              err_q, err_d;            // transaction ended by timeout
  logic              mem_ren_q, mem_ren_d;
  logic              mem_wen_q, mem_wen_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              bus_err_q, bus_err_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic d_req;
  logic pick_data;
  logic timeout;

  assign d_req   = d_ren | d_wen;
  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES));

`ifdef ARB_ROUND_ROBIN_EN
  logic rr_last_q, rr_last_d;  // 1: data port granted last, 0: fetch port
  assign pick_data = d_req & (~if_req | ~rr_last_q);
`else
  assign pick_data = d_req;
`endif

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    gnt_data_d  = gnt_data_q;
    wr_d        = wr_q;
    err_d       = err_q;
    mem_ren_d   = 1'b0;
    mem_wen_d   = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    rr_last_d   = rr_last_q;
`endif

    case (state_q)
      IDLE: begin
        // An ack still showing means the requester has not yet seen it, so
        // its request level is stale for this cycle.
        if (!if_ack_q && !d_ack_q && mem_ready && (d_req || if_req)) begin
          state_d    = ISSUE;
          cnt_d      = '0;
          err_d      = 1'b0;
          gnt_data_d = pick_data;
`ifdef ARB_ROUND_ROBIN_EN
          rr_last_d  = pick_data;
`endif
          if (pick_data) begin
            wr_d        = d_wen;
            mem_wen_d   = d_wen;
            mem_ren_d   = ~d_wen;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_wen ? d_be : 4'hF;
          end else begin
            wr_d        = 1'b0;
            mem_ren_d   = 1'b1;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = 4'hF;
          end
        end
      end

      ISSUE: state_d = WAIT_LOW;

      WAIT_LOW, WAIT_HIGH: begin
        if (timeout) begin
          err_d   = 1'b1;
          state_d = RESP;
          if (gnt_data_q) d_rdata_d  = '0;
          else            if_rdata_d = '0;
        end else if (state_q == WAIT_LOW) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (!mem_ready) state_d = WAIT_HIGH;
        end else if (mem_ready) begin
          state_d = RESP;
          if (!gnt_data_q)  if_rdata_d = mem_rdata;
          else if (!wr_q)   d_rdata_d  = mem_rdata;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        if_ack_d  = ~gnt_data_q;
        d_ack_d   = gnt_data_q;
        bus_err_d = err_q;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge cpu_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      gnt_data_q  <= 1'b0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      mem_ren_q   <= 1'b0;
      mem_wen_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      bus_err_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      gnt_data_q  <= gnt_data_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      mem_ren_q   <= mem_ren_d;
      mem_wen_q   <= mem_wen_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      bus_err_q   <= bus_err_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef ARB_ROUND_ROBIN_EN
      rr_last_q   <= rr_last_d;
`endif
    end
  end

  assign mem_ren   = mem_ren_q;
  assign mem_wen   = mem_wen_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign bus_err   = bus_err_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule
